watchdog_sequencer: RTL and testbench
=====================================

Name: watchdog_sequencer

Overview:
Controller that owns one watchdog instance and runs complete "wait-for-signal" checks for a single requester.
- Clears and arms the watchdog.
- Qualifies the match indication over a hold window.
- On timeout, backs off and retries up to a limit.
- Reports a final pass/fail result.

The block sits between link/bring-up control logic and the watchdog: it drives the watchdog's reset and timer-enable, and consumes its timeout and match events.

Parameters:
- RETRY_MAX, 3, number of retries after the first attempt (total attempts = RETRY_MAX+1).
- RETRY_W, 4, width of the attempt counter and o_attempts; must hold RETRY_MAX+1.
- MATCH_HOLD, 16, consecutive i_match_event cycles required to declare pass; must be >= 1.
- CLR_CYCLES, 2, cycles o_wd_rst is held before arming; must be >= 2 to flush the watchdog's registered outputs.
- BACKOFF_CYCLES, 1000, idle cycles between a timeout and the next clear/arm.

Ports:
- i_clk, input, 1, 100 MHz system clock.
- i_rst, input, 1, asynchronous active-high reset.
- i_start, input, 1, single-cycle request to begin a check; ignored while o_busy=1.
- i_abort, input, 1, terminate the current check with a fail result.
- i_timeout_event, input, 1, watchdog timeout indication.
- i_match_event, input, 1, watchdog signal-match indication.
- o_wd_rst, output, 1, synchronous clear to the watchdog.
- o_timer_en, output, 1, watchdog timer enable.
- o_busy, output, 1, high from the cycle after accepted start until DONE exits.
- o_done, output, 1, single-cycle completion pulse.
- o_pass, output, 1, sticky result: matched.
- o_fail, output, 1, sticky result: retries exhausted or aborted.
- o_attempts, output, RETRY_W, number of attempts used in the last or current check.

Behaviour:
Clocking and reset
- All outputs are registered.
- Reset (async assert, sync release via i_clk) forces: state IDLE; o_wd_rst=1; o_timer_en=0; o_busy=0; o_done=0; o_pass=0; o_fail=0; o_attempts=0; all internal counters 0.

State machine: IDLE, CLEAR, ARM, BACKOFF, DONE.
- IDLE: o_wd_rst=1, o_timer_en=0. On i_start=1, next cycle enters CLEAR with: o_busy=1; o_pass=0, o_fail=0; o_attempts=1; clr_cnt=0.
- CLEAR: o_wd_rst=1, o_timer_en=0, for exactly CLR_CYCLES cycles, then ARM with match_cnt=0.
- ARM: o_wd_rst=0, o_timer_en=1.
  - match_cnt increments each cycle i_match_event=1 and clears to 0 on any cycle with i_match_event=0.
  - Pass: when i_match_event=1 and match_cnt==MATCH_HOLD-1, go to DONE with pass.
  - Timeout (and no pass in the same cycle):
    - If o_attempts==RETRY_MAX+1, go to DONE with fail.
    - Otherwise go to BACKOFF, o_attempts+1.
  - Pass and timeout in the same cycle: pass wins.
- BACKOFF: o_wd_rst=1, o_timer_en=0 for BACKOFF_CYCLES cycles, then CLEAR. Events are ignored.
- DONE: lasts one cycle.
  - o_done=1; o_pass or o_fail set (sticky until the next accepted start); o_wd_rst=1; o_timer_en=0.
  - Next state IDLE, with o_busy=0 in that same cycle.
  - i_start arriving in DONE is ignored.

Abort and other boundaries
- i_abort=1 in CLEAR/ARM/BACKOFF goes to DONE with fail, o_attempts unchanged. Abort has priority over pass and timeout in the same cycle. i_abort in IDLE or DONE has no effect.
- i_start and i_abort together in IDLE: start is accepted, abort is ignored.
- Reset mid-check: immediate return to reset values; no o_done pulse.
- The counters never wrap. clr_cnt, backoff_cnt and match_cnt are sized with $clog2 of their limits plus 1.

Test Plan:
All scenarios use MATCH_HOLD=4, CLR_CYCLES=2, BACKOFF_CYCLES=8, RETRY_MAX=2.
1. Immediate pass: pulse i_start; hold i_match_event=1 from the first ARM cycle. Required: o_timer_en high for 4 cycles; o_done pulse with o_pass=1, o_fail=0, o_attempts=1; o_busy low the cycle after o_done.
2. Broken match window: in ARM drive i_match_event 1,1,1,0,1,1,1,1. Required: pass only on the 4th consecutive high (the 8th ARM cycle), o_attempts=1.
3. Exhaust retries: i_match_event=0; pulse i_timeout_event in each ARM. Required:
   - 2 BACKOFF periods of 8 cycles, each followed by 2 CLEAR cycles with o_wd_rst=1.
   - Third timeout gives o_done with o_fail=1, o_attempts=3.
4. Simultaneous pass and timeout: timeout asserted on the cycle the 4th match completes. Required: o_pass=1, o_fail=0, no BACKOFF.
5. Abort during BACKOFF (cycle 3) after one timeout. Required: next cycle o_done=1, o_fail=1, o_attempts=2, o_timer_en=0. A subsequent i_start clears o_fail and restarts with o_attempts=1.
6. Async reset asserted mid-ARM between clock edges. Required: o_timer_en=0, o_wd_rst=1, o_busy=0 immediately, with no o_done pulse; i_start pulses while busy (single attempt) are ignored with no restart.

Source files
------------

// File: rtl/watchdog_sequencer.sv
// watchdog_sequencer: clears, arms and qualifies one watchdog, retrying on timeout
// and reporting a sticky pass/fail result per check.
module watchdog_sequencer #(
  parameter int RETRY_MAX      = 3,
  parameter int RETRY_W        = 4,
  parameter int MATCH_HOLD     = 16,
  parameter int CLR_CYCLES     = 2,
  parameter int BACKOFF_CYCLES = 1000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_timeout_event,
  input  logic               i_match_event,
  output logic               o_wd_rst,
  output logic               o_timer_en,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic               o_fail,
  output logic [RETRY_W-1:0] o_attempts
);
  localparam int CW = $clog2(CLR_CYCLES) + 1;
  localparam int BW = $clog2(BACKOFF_CYCLES) + 1;
  localparam int MW = $clog2(MATCH_HOLD) + 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);
  localparam logic [BW-1:0] BO_LAST = BW'(BACKOFF_CYCLES - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_HOLD - 1);
  localparam logic [RETRY_W-1:0] ATT_LAST = RETRY_W'(RETRY_MAX + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, ARM, BACKOFF, DONE} state_e;

  state_e state_q, state_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;
  logic [BW-1:0] bo_cnt_q, bo_cnt_d;
  logic [MW-1:0] match_cnt_q, match_cnt_d;
  logic [RETRY_W-1:0] att_q, att_d;
  logic pass_q, pass_d, fail_q, fail_d;
  logic wd_rst_q, timer_en_q, busy_q, done_q;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    bo_cnt_d    = bo_cnt_q;
    match_cnt_d = match_cnt_q;
    att_d       = att_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    case (state_q)
      IDLE: if (i_start) begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
        att_d     = RETRY_W'(1);
        pass_d    = 1'b0;
        fail_d    = 1'b0;
      end
      CLEAR: if (i_abort) begin
        state_d = DONE;
        fail_d  = 1'b1;
      end else if (clr_cnt_q == CLR_LAST) begin
        state_d     = ARM;
        match_cnt_d = '0;
      end else clr_cnt_d = clr_cnt_q + 1'b1;
      ARM: begin
        match_cnt_d = i_match_event ? match_cnt_q + 1'b1 : '0;
        // Priority: abort, then pass, then timeout.
        if (i_abort) begin
          state_d = DONE;
          fail_d  = 1'b1;
        end else if (i_match_event && match_cnt_q == MATCH_LAST) begin
          state_d = DONE;
          pass_d  = 1'b1;
        end else if (i_timeout_event && att_q == ATT_LAST) begin
          state_d = DONE;
          fail_d  = 1'b1;
        end else if (i_timeout_event) begin
          state_d  = BACKOFF;
          bo_cnt_d = '0;
          att_d    = att_q + 1'b1;
        end
      end
      BACKOFF: if (i_abort) begin
        state_d = DONE;
        fail_d  = 1'b1;
      end else if (bo_cnt_q == BO_LAST) begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end else bo_cnt_d = bo_cnt_q + 1'b1;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      bo_cnt_q    <= '0;
      match_cnt_q <= '0;
      att_q       <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      wd_rst_q    <= 1'b1;
      timer_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      bo_cnt_q    <= bo_cnt_d;
      match_cnt_q <= match_cnt_d;
      att_q       <= att_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      wd_rst_q    <= state_d != ARM;
      timer_en_q  <= state_d == ARM;
      busy_q      <= state_d != IDLE;
      done_q      <= state_d == DONE;
    end
  end

  assign o_wd_rst   = wd_rst_q;
  assign o_timer_en = timer_en_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_pass     = pass_q;
  assign o_fail     = fail_q;
  assign o_attempts = att_q;
endmodule

// File: tb/tb_watchdog_sequencer.sv
// tb_watchdog_sequencer: directed and random stimulus against a phase/countdown
// reference model of the check procedure.
module tb_watchdog_sequencer;
  localparam int RMAX = 2, RW = 4, MH = 4, CLR = 2, BO = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, tmo = 1'b0, match = 1'b0;
  logic wd_rst, timer_en, busy, done, pass, fail;
  logic [RW-1:0] attempts;
  int n_cmp = 0, n_err = 0;
  int ph, left, run, att, k;
  bit m_pass, m_fail;

  watchdog_sequencer #(
    .RETRY_MAX(RMAX), .RETRY_W(RW), .MATCH_HOLD(MH), .CLR_CYCLES(CLR), .BACKOFF_CYCLES(BO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_timeout_event(tmo), .i_match_event(match),
    .o_wd_rst(wd_rst), .o_timer_en(timer_en), .o_busy(busy), .o_done(done),
    .o_pass(pass), .o_fail(fail), .o_attempts(attempts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    ph = 0; left = 0; run = 0; att = 0; k = 0; m_pass = 0; m_fail = 0;
  endtask

  // Phases: 0 idle, 1 clear, 2 arm, 3 backoff, 4 done; left counts cycles remaining.
  task automatic m_step();
    int prev = ph;
    case (ph)
      0: if (start) begin ph = 1; left = CLR; att = 1; m_pass = 0; m_fail = 0; end
      1, 3: if (abort) begin ph = 4; m_fail = 1; end
        else begin
          left--;
          if (left == 0) begin
            if (ph == 1) begin ph = 2; run = 0; end
            else begin ph = 1; left = CLR; end
          end
        end
      2: if (abort) begin ph = 4; m_fail = 1; end
        else begin
          run = match ? run + 1 : 0;
          if (run == MH) begin ph = 4; m_pass = 1; end
          else if (tmo) begin
            if (att == RMAX + 1) begin ph = 4; m_fail = 1; end
            else begin ph = 3; left = BO; att++; end
          end
        end
      default: ph = 0;
    endcase
    k = (ph == prev) ? k + 1 : 0;
  endtask

  task automatic check_all();
    check("wd_rst", wd_rst, ph != 2);
    check("timer_en", timer_en, ph == 2);
    check("busy", busy, ph != 0);
    check("done", done, ph == 4);
    check("pass", pass, m_pass);
    check("fail", fail, m_fail);
    check("attempts", attempts, att);
  endtask

  task automatic drive(input int mode);
    start = 1'b0; abort = 1'b0; tmo = 1'b0; match = 1'b0;
    case (mode)
      1: begin start = ph == 0; match = 1'b1; end
      2: begin start = ph == 0; tmo = ph == 2; end
      3: begin start = ph == 0; match = !(ph == 2 && k == 3); end
      4: begin start = ph == 0; match = 1'b1; tmo = ph == 2 && k == 3; end
      5: begin start = ph == 0; tmo = ph == 2; abort = ph == 3 && k == 2; end
      6: begin start = ph == 0 || $urandom_range(1) == 1; abort = $urandom_range(1) == 1; end
      default: begin
        start = $urandom_range(7) == 0;
        abort = $urandom_range(63) == 0;
        tmo   = $urandom_range(15) == 0;
        match = $urandom_range(7) != 0;
      end
    endcase
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;
    for (int mode = 1; mode <= 7; mode++) begin
      for (int i = 0; i < (mode == 7 ? 3000 : 60); i++) begin
        drive(mode % 7);
        if ((mode == 6 && ph == 2 && k == 1) || (mode == 7 && $urandom_range(399) == 0)) begin
          #2 rst = 1'b1;
          #1;
          check("async_wd_rst", wd_rst, 1'b1);
          check("async_timer_en", timer_en, 1'b0);
          check("async_busy", busy, 1'b0);
          check("async_done", done, 1'b0);
          check("async_attempts", attempts, 0);
          m_reset();
        end
        @(posedge clk);
        if (rst) m_reset();
        else m_step();
        @(negedge clk);
        rst = 1'b0;
        check_all();
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
